// File: rtl/qspi_mem_model.sv
// Multi-device SPI/QSPI memory model: oversamples sclk/cs_n in the clk domain and serves
// READ/FAST/QUAD reads and single/quad writes from per-device byte arrays with a backdoor port.
module qspi_mem_model #(
  parameter int                 NUM_DEV       = 2,
  parameter int                 DEPTH_BYTES   = 4096,
  parameter int                 ADDR_BITS     = 24,
  parameter logic [NUM_DEV-1:0] WRITABLE_MASK = 2'b10,
  parameter int                 DUMMY_FAST    = 8,
  parameter int                 DUMMY_QUAD    = 6,
  localparam int                DEV_W         = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1,
  localparam int                AW            = $clog2(DEPTH_BYTES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DEV-1:0] cs_n,
  input  logic               sclk,
  input  logic [3:0]         io_in,
  output logic [3:0]         io_out,
  output logic [3:0]         io_oe,
  input  logic               bd_we,
  input  logic [DEV_W-1:0]   bd_dev,
  input  logic [AW-1:0]      bd_addr,
  input  logic [7:0]         bd_wdata,
  output logic [7:0]         bd_rdata,
  output logic               busy,
  output logic               err_pulse
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_t;

  localparam int              MW          = DEV_W + AW;
  localparam int              WM_W        = 1 << DEV_W;
  localparam logic [WM_W-1:0] WMASK       = WM_W'(WRITABLE_MASK);
  localparam logic [7:0]      ADDR_LAST_S = 8'(ADDR_BITS - 1);
  localparam logic [7:0]      ADDR_LAST_Q = 8'(ADDR_BITS / 4 - 1);

  logic [7:0]         mem_r [0:(1 << MW) - 1];
  state_t             state_r, state_nxt_s;
  logic               sclk_q_r;
  logic [NUM_DEV-1:0] cs_q_r;
  logic [6:0]         cmd_r;
  logic [7:0]         cnt_r, dummy_r, wbyte_r;
  logic [AW-1:0]      addr_r;
  logic [DEV_W-1:0]   dev_r, sel_dev_s;
  logic               quad_r, rd_r, werr_r;
  logic [3:0]         io_out_r, io_oe_r;
  logic               busy_r, err_pulse_r;
  logic [7:0]         bd_rdata_r;
  logic [2:0]         n_low_s;
  logic               rise_s, fall_s, cs_idle_s, cs_edge_s, one_sel_s, err_s;
  logic [7:0]         op_s, rd_byte_s, bus_wdata_s;
  logic               op_valid_s, writable_s, addr_last_s, dummy_last_s, byte_last_s, bus_we_s;
  logic [MW-1:0]      bus_idx_s, bd_idx_s;

  assign rise_s       = sclk & ~sclk_q_r;
  assign fall_s       = ~sclk & sclk_q_r;
  assign cs_idle_s    = &cs_n;
  assign cs_edge_s    = (&cs_q_r) & ~cs_idle_s;
  assign one_sel_s    = (n_low_s == 3'd1);
  assign op_s         = {cmd_r, io_in[0]};
  assign op_valid_s   = (op_s == 8'h03) || (op_s == 8'h0B) || (op_s == 8'hEB) ||
                        (op_s == 8'h02) || (op_s == 8'h38);
  assign writable_s   = WMASK[dev_r];
  assign addr_last_s  = rise_s && (cnt_r == (quad_r ? ADDR_LAST_Q : ADDR_LAST_S));
  assign dummy_last_s = rise_s && (cnt_r == dummy_r - 8'd1);
  assign byte_last_s  = (cnt_r == (quad_r ? 8'd1 : 8'd7));
  assign bus_idx_s    = {dev_r, addr_r};
  assign bd_idx_s     = {bd_dev, bd_addr};
  assign rd_byte_s    = mem_r[bus_idx_s];
  assign bus_wdata_s  = quad_r ? {wbyte_r[3:0], io_in} : {wbyte_r[6:0], io_in[0]};
  assign bus_we_s     = (state_r == ST_WDATA) && rise_s && byte_last_s && writable_s && !cs_idle_s;

  assign io_out    = io_out_r;
  assign io_oe     = io_oe_r;
  assign busy      = busy_r;
  assign err_pulse = err_pulse_r;
  assign bd_rdata  = bd_rdata_r;

  // Count asserted chip-selects and pick the (last) selected device index
  always_comb begin
    n_low_s   = 3'd0;
    sel_dev_s = '0;
    for (int d = 0; d < NUM_DEV; d++) begin
      n_low_s   = n_low_s + {2'b00, ~cs_n[d]};
      sel_dev_s = (!cs_n[d]) ? DEV_W'(d) : sel_dev_s;
    end
  end

  // Next-state logic and protocol-error detection
  always_comb begin
    state_nxt_s = state_r;
    err_s       = 1'b0;
    if (cs_idle_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cs_edge_s && one_sel_s) begin
            state_nxt_s = ST_CMD;
          end else if (cs_edge_s) begin
            err_s       = 1'b1;
            state_nxt_s = ST_IGNORE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (rise_s && cnt_r == 8'd7 && op_valid_s) begin
            state_nxt_s = ST_ADDR;
          end else if (rise_s && cnt_r == 8'd7) begin
            err_s       = 1'b1;
            state_nxt_s = ST_IGNORE;
          end else begin
            state_nxt_s = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (addr_last_s && dummy_r != 8'd0) begin
            state_nxt_s = ST_DUMMY;
          end else if (addr_last_s) begin
            state_nxt_s = rd_r ? ST_RDATA : ST_WDATA;
          end else begin
            state_nxt_s = ST_ADDR;
          end
        end
        ST_DUMMY: begin
          if (dummy_last_s) begin
            state_nxt_s = ST_RDATA;
          end else begin
            state_nxt_s = ST_DUMMY;
          end
        end
        ST_WDATA: begin
          if (rise_s && byte_last_s && !writable_s && !werr_r) begin
            err_s = 1'b1;
          end else begin
            err_s = 1'b0;
          end
        end
        default: state_nxt_s = state_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Bus sampling, shift registers, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q_r <= 1'b0;      cs_q_r  <= '1;    cmd_r   <= 7'd0;  cnt_r  <= 8'd0;
      dummy_r  <= 8'd0;      wbyte_r <= 8'd0;  addr_r  <= '0;    dev_r  <= '0;
      quad_r   <= 1'b0;      rd_r    <= 1'b0;  werr_r  <= 1'b0;  io_out_r <= 4'h0;
      io_oe_r  <= 4'h0;      busy_r  <= 1'b0;  err_pulse_r <= 1'b0; bd_rdata_r <= 8'h00;
    end else begin
      sclk_q_r    <= sclk;
      cs_q_r      <= cs_n;
      err_pulse_r <= err_s;
      bd_rdata_r  <= mem_r[bd_idx_s];
      case (state_r)
        ST_IDLE: begin
          dev_r  <= sel_dev_s;
          cnt_r  <= 8'd0;
          werr_r <= 1'b0;
          busy_r <= (state_nxt_s == ST_CMD);
        end
        ST_CMD: if (rise_s) begin
          cmd_r <= op_s[6:0];
          cnt_r <= cnt_r + 8'd1;
          if (cnt_r == 8'd7) begin
            cnt_r   <= 8'd0;
            quad_r  <= (op_s == 8'hEB) || (op_s == 8'h38);
            rd_r    <= (op_s == 8'h03) || (op_s == 8'h0B) || (op_s == 8'hEB);
            dummy_r <= (op_s == 8'h0B) ? 8'(DUMMY_FAST) :
                       (op_s == 8'hEB) ? 8'(DUMMY_QUAD) : 8'd0;
          end
        end
        ST_ADDR: if (rise_s) begin
          addr_r <= quad_r ? {addr_r[AW-5:0], io_in} : {addr_r[AW-2:0], io_in[0]};
          cnt_r  <= addr_last_s ? 8'd0 : cnt_r + 8'd1;
        end
        ST_DUMMY: if (rise_s) cnt_r <= dummy_last_s ? 8'd0 : cnt_r + 8'd1;
        // High nibble / MSB first; the address advances after the last slice of a byte
        ST_RDATA: if (fall_s) begin
          io_oe_r  <= quad_r ? 4'hF : 4'b0010;
          io_out_r <= quad_r ? (cnt_r[0] ? rd_byte_s[3:0] : rd_byte_s[7:4])
                             : {2'b00, rd_byte_s[3'd7 - cnt_r[2:0]], 1'b0};
          cnt_r    <= byte_last_s ? 8'd0 : cnt_r + 8'd1;
          if (byte_last_s) addr_r <= addr_r + 1'b1;
        end
        ST_WDATA: if (rise_s) begin
          wbyte_r <= bus_wdata_s;
          cnt_r   <= byte_last_s ? 8'd0 : cnt_r + 8'd1;
          if (byte_last_s) begin
            addr_r <= addr_r + 1'b1;
            if (!writable_s) werr_r <= 1'b1;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
      if (state_nxt_s == ST_IDLE) begin
        io_oe_r  <= 4'h0;
        io_out_r <= 4'h0;
        busy_r   <= 1'b0;
      end
    end
  end

  // Memory array: survives reset; a bus write beats a backdoor write to the same byte
  always_ff @(posedge clk) begin
    if (bus_we_s) mem_r[bus_idx_s] <= bus_wdata_s;
    if (bd_we && !(bus_we_s && (bus_idx_s == bd_idx_s))) mem_r[bd_idx_s] <= bd_wdata;
  end

endmodule
